lcd_num_printer: RTL and testbench
==================================

Name: lcd_num_printer

Overview:
Upstream character source for the 16x2 character-LCD driver. Accepts a 16-bit binary value on a start pulse and converts it to decimal ASCII using sequential repeated subtraction. Streams the resulting characters one byte per write strobe on the driver's write_en/data interface, optionally followed by a carriage return (0x0D). Used by datapath/debug logic to print numbers on the display without software.

Parameters:
GAP, 4, minimum idle cycles with lcd_we low after every write strobe before the next strobe (0 allowed)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request; accepted only when busy=0
value  input  16  number to print; sampled on accepted start
signed_mode  input  1  1: value is two's complement; 0: unsigned; sampled on accepted start
newline  input  1  1: append 0x0D after the last digit; sampled on accepted start
busy  output  1  high from the cycle after an accepted start until done is asserted
done  output  1  one-cycle pulse after the final character's GAP has elapsed
lcd_we  output  1  one-cycle write strobe to the LCD driver
lcd_data  output  8  ASCII byte; valid while lcd_we=1, held otherwise

Behaviour:
- Reset (async): state=IDLE; busy=0, done=0, lcd_we=0, lcd_data=0x00; remainder, digit counter, power index and gap counter all cleared. Reset mid-conversion aborts with no further strobes.
- Accepted start (IDLE, start=1):
  - latch value, signed_mode, newline.
  - compute mag: |value| if signed_mode=1 and value[15]=1, else value; 16-bit unsigned; 0x8000 gives 32768.
  - latch neg flag.
  - next state SIGN if neg, else DIGIT; busy=1 next cycle.
- start while busy: ignored, no effect on the in-flight conversion.
- Powers table: 10000, 1000, 100, 10, 1; pidx 0..4 (3 bits). Remainder is 16 bits; digit counter is 4 bits.
- States:
  - IDLE: waits for start.
  - SIGN: strobe lcd_we=1 with lcd_data=0x2D ('-'), then GAP.
  - DIGIT: one compare per cycle.
    - If rem >= POW[pidx]: rem <= rem-POW[pidx], dig <= dig+1.
    - Else: digit complete; go to EMIT.
  - EMIT:
    - If dig=0, no digit emitted yet, and pidx<4: suppress the zero, no strobe.
    - Otherwise strobe lcd_data=0x30+dig and mark digit emitted.
    - Then clear dig and increment pidx.
    - If pidx was 4: go to CR if newline, else FIN; otherwise DIGIT.
    - If a strobe occurred, pass through GAP first.
  - GAP: count GAP cycles with lcd_we=0, then resume the stored next state. GAP=0 means no extra cycles.
  - CR: strobe lcd_data=0x0D, then GAP, then FIN.
  - FIN: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- Value 0 prints the single character "0" (the last digit is never suppressed).
- Strobe timing:
  - lcd_we is never high in two consecutive cycles when GAP≥1.
  - Spacing between strobes is ≥ GAP+1 cycles.
  - Per-digit conversion takes ≤10 cycles plus EMIT.
- lcd_data holds its last value between strobes.
- Total latency bound: ≤ 7 strobes × (GAP+1) + 5×11 + 3 cycles.

Decomposition:
- Shared package lcd_pkg holds:
  - ASCII constants: ASCII_0=8'h30, ASCII_MINUS=8'h2D, ASCII_CR=8'h0D, ASCII_SPACE=8'h20.
  - POW10 constant array of 16-bit values.
  - Printer state enum: IDLE, SIGN, DIGIT, EMIT, GAP, CR, FIN.
- No sub-module; single FSM with datapath, roughly 150–200 lines.

Test Plan:
- GAP=4, value=0, signed_mode=0, newline=0 -> exactly one strobe with data 0x30; done pulses; busy low afterwards.
- value=16'hFFFF, unsigned -> strobes 0x36,0x35,0x35,0x33,0x35 ("65535"); consecutive strobes ≥5 cycles apart.
- value=16'h8000, signed_mode=1, newline=1 -> "-32768" then 0x0D (0x2D,0x33,0x32,0x37,0x36,0x38,0x0D).
- value=16'd1234 unsigned with a second start (value=9) pulsed mid-conversion -> only "1234" is emitted; a start after done prints "9".
- value=16'hFFFF signed (-1), newline=0 -> "-1" (0x2D,0x31); value=100 unsigned -> "100" (zero suppression is leading-only).
- Assert reset during the third digit of 54321 -> lcd_we=0 and busy=0 immediately; no further strobes; a new start prints correctly.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants and state encoding for the LCD number printer.
// Decimal digit weights live here so the printer's compare loop stays table-driven.
package lcd_pkg;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  localparam logic [15:0] POW10 [5] = '{16'd10000, 16'd1000, 16'd100, 16'd10, 16'd1};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SIGN  = 3'd1,
    ST_DIGIT = 3'd2,
    ST_EMIT  = 3'd3,
    ST_GAP   = 3'd4,
    ST_CR    = 3'd5,
    ST_FIN   = 3'd6
  } printer_state_e;

  // Out-of-range indices map to 1 so a stray index can never stall the subtract loop.
  function automatic logic [15:0] pow10(input logic [2:0] idx);
    case (idx)
      3'd0:    pow10 = POW10[0];
      3'd1:    pow10 = POW10[1];
      3'd2:    pow10 = POW10[2];
      3'd3:    pow10 = POW10[3];
      default: pow10 = POW10[4];
    endcase
  endfunction

endpackage

// File: rtl/lcd_num_printer.sv
// Converts a 16-bit value to decimal ASCII by repeated subtraction and streams
// the characters to the character-LCD driver, one strobe per byte.
module lcd_num_printer
  import lcd_pkg::*;
#(
  parameter int GAP = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] value,
  input  logic        signed_mode,
  input  logic        newline,
  output logic        busy,
  output logic        done,
  output logic        lcd_we,
  output logic [7:0]  lcd_data
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  printer_state_e state, ret_state, after_emit;
  logic [15:0]    rem, pow, mag;
  logic [3:0]     dig;
  logic [2:0]     pidx;
  logic [GW-1:0]  gap_cnt;
  logic           emitted, nl_q, neg, suppress;

  always_comb begin
    pow      = pow10(pidx);
    neg      = signed_mode & value[15];
    mag      = neg ? (~value + 16'd1) : value;
    // Only leading zeros are dropped; the units digit always prints.
    suppress = (dig == 4'd0) && !emitted && (pidx != 3'd4);
    if (pidx == 3'd4) after_emit = nl_q ? ST_CR : ST_FIN;
    else              after_emit = ST_DIGIT;
  end

  assign busy = (state != ST_IDLE) && (state != ST_FIN);
  assign done = (state == ST_FIN);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      ret_state <= ST_IDLE;
      rem       <= '0;
      dig       <= '0;
      pidx      <= '0;
      gap_cnt   <= '0;
      emitted   <= 1'b0;
      nl_q      <= 1'b0;
      lcd_we    <= 1'b0;
      lcd_data  <= 8'h00;
    end else begin
      lcd_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            rem     <= mag;
            nl_q    <= newline;
            dig     <= '0;
            pidx    <= '0;
            emitted <= 1'b0;
            state   <= neg ? ST_SIGN : ST_DIGIT;
          end
        end
        ST_SIGN: begin
          lcd_we   <= 1'b1;
          lcd_data <= ASCII_MINUS;
          if (GAP == 0) state <= ST_DIGIT;
          else begin
            state     <= ST_GAP;
            ret_state <= ST_DIGIT;
            gap_cnt   <= GW'(GAP - 1);
          end
        end
        ST_DIGIT: begin
          if (rem >= pow) begin
            rem <= rem - pow;
            dig <= dig + 4'd1;
          end else begin
            state <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          dig  <= '0;
          pidx <= pidx + 3'd1;
          if (suppress) state <= after_emit;
          else begin
            lcd_we   <= 1'b1;
            lcd_data <= ASCII_0 + {4'd0, dig};
            emitted  <= 1'b1;
            if (GAP == 0) state <= after_emit;
            else begin
              state     <= ST_GAP;
              ret_state <= after_emit;
              gap_cnt   <= GW'(GAP - 1);
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) state <= ret_state;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        ST_CR: begin
          lcd_we   <= 1'b1;
          lcd_data <= ASCII_CR;
          if (GAP == 0) state <= ST_FIN;
          else begin
            state     <= ST_GAP;
            ret_state <= ST_FIN;
            gap_cnt   <= GW'(GAP - 1);
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_num_printer.sv
// Vector-table bench for lcd_num_printer: expected characters go into a
// scoreboard queue at start time and are popped as strobes appear.
module tb_lcd_num_printer;

  localparam int GAP = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] value = '0;
  logic        signed_mode = 1'b0;
  logic        newline = 1'b0;
  logic        busy, done, lcd_we;
  logic [7:0]  lcd_data;

  lcd_num_printer #(.GAP(GAP)) dut (
    .clock(clock), .reset(reset), .start(start), .value(value),
    .signed_mode(signed_mode), .newline(newline), .busy(busy), .done(done),
    .lcd_we(lcd_we), .lcd_data(lcd_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] value;
    logic        sgn;
    logic        nl;
    bit          inject;
    string       text;
  } vec_t;

  vec_t       vecs [11];
  logic [7:0] sb [$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         last_strobe = -1;
  int         strobe_cnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Strobe monitor: data against scoreboard, spacing against GAP.
  always @(negedge clock) begin
    if (!reset && lcd_we) begin
      logic [7:0] exp_b;
      strobe_cnt = strobe_cnt + 1;
      checks = checks + 1;
      if (sb.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_strobe data=%02h expected no strobe", lcd_data);
      end else begin
        exp_b = sb.pop_front();
        if (lcd_data !== exp_b) begin
          errors = errors + 1;
          $display("FAIL strobe_data got=%02h expected=%02h", lcd_data, exp_b);
        end
      end
      if (last_strobe >= 0) begin
        checks = checks + 1;
        if (cyc - last_strobe < GAP + 1) begin
          errors = errors + 1;
          $display("FAIL strobe_spacing got=%0d cycles expected>=%0d", cyc - last_strobe, GAP + 1);
        end
      end
      last_strobe = cyc;
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp_v);
    checks = checks + 1;
    if (got !== exp_v) begin
      errors = errors + 1;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp_v);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int nchars, lat;
    bit seen;
    nchars = v.text.len() + (v.nl ? 1 : 0);
    @(negedge clock);
    last_strobe = -1;
    for (int i = 0; i < v.text.len(); i++) sb.push_back(8'(v.text[i]));
    if (v.nl) sb.push_back(8'h0D);
    value = v.value; signed_mode = v.sgn; newline = v.nl; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    value = 16'($urandom); signed_mode = ~v.sgn; newline = ~v.nl;
    check("busy_after_start", {15'd0, busy}, 16'd1);
    if (v.inject) begin
      repeat (8) @(negedge clock);
      value = 16'd9; signed_mode = 1'b0; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    lat = 0; seen = 0;
    for (int c = 0; c < 400; c++) begin
      if (done) begin seen = 1; break; end
      @(negedge clock);
      lat++;
    end
    check("done_seen", {15'd0, seen}, 16'd1);
    if (seen) begin
      check("busy_at_done", {15'd0, busy}, 16'd0);
      check("chars_left", 16'(sb.size()), 16'd0);
      checks = checks + 1;
      if (lat > nchars * (GAP + 1) + 58) begin
        errors = errors + 1;
        $display("FAIL latency got=%0d expected<=%0d", lat, nchars * (GAP + 1) + 58);
      end
      @(negedge clock);
      check("done_pulse_width", {15'd0, done}, 16'd0);
      check("busy_after_done", {15'd0, busy}, 16'd0);
    end
    sb.delete();
  endtask

  initial begin
    vec_t r;
    bit   seen;
    vecs[0]  = '{16'd0,     1'b0, 1'b0, 1'b0, "0"};
    vecs[1]  = '{16'hFFFF,  1'b0, 1'b0, 1'b0, "65535"};
    vecs[2]  = '{16'h8000,  1'b1, 1'b1, 1'b0, "-32768"};
    vecs[3]  = '{16'd1234,  1'b0, 1'b0, 1'b1, "1234"};
    vecs[4]  = '{16'd9,     1'b0, 1'b0, 1'b0, "9"};
    vecs[5]  = '{16'hFFFF,  1'b1, 1'b0, 1'b0, "-1"};
    vecs[6]  = '{16'd100,   1'b0, 1'b0, 1'b0, "100"};
    vecs[7]  = '{16'h8000,  1'b0, 1'b0, 1'b0, "32768"};
    vecs[8]  = '{16'h7FFF,  1'b1, 1'b1, 1'b0, "32767"};
    vecs[9]  = '{16'd10,    1'b1, 1'b0, 1'b0, "10"};
    vecs[10] = '{16'hFF9C,  1'b1, 1'b0, 1'b0, "-100"};

    repeat (3) @(negedge clock);
    check("reset_busy", {15'd0, busy}, 16'd0);
    check("reset_done", {15'd0, done}, 16'd0);
    check("reset_we", {15'd0, lcd_we}, 16'd0);
    check("reset_data", {8'd0, lcd_data}, 16'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Reset while the third digit of 54321 is being converted.
    @(negedge clock);
    last_strobe = -1;
    strobe_cnt = 0;
    for (int i = 0; i < 5; i++) sb.push_back(8'h30 + 8'(5 - i));
    value = 16'd54321; signed_mode = 1'b0; newline = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      if (strobe_cnt >= 2) begin seen = 1; break; end
      @(negedge clock);
    end
    check("second_digit_seen", {15'd0, seen}, 16'd1);
    repeat (GAP + 2) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("midreset_we", {15'd0, lcd_we}, 16'd0);
    check("midreset_busy", {15'd0, busy}, 16'd0);
    check("midreset_data", {8'd0, lcd_data}, 16'd0);
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    strobe_cnt = 0;
    repeat (60) @(negedge clock);
    check("strobes_after_reset", 16'(strobe_cnt), 16'd0);
    check("idle_after_reset", {15'd0, busy}, 16'd0);
    r = '{16'd54321, 1'b0, 1'b0, 1'b0, "54321"};
    run_vec(r);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
